// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types and constants for the continuous monitoring system; this slice carries
// the trace filter run-controller definitions.
package continuous_monitoring_system_pkg;

  localparam int unsigned RISC_V_INSTRUCTION_WIDTH = 32;
  localparam int unsigned TRACE_PC_WIDTH           = 64;

  typedef enum logic [1:0] {
    TFC_IDLE    = 2'd0,
    TFC_ARMED   = 2'd1,
    TFC_RUNNING = 2'd2,
    TFC_DONE    = 2'd3
  } trace_ctrl_state_t;

  localparam logic [2:0] TFC_CTRL     = 3'd0;
  localparam logic [2:0] TFC_START_PC = 3'd1;
  localparam logic [2:0] TFC_END_PC   = 3'd2;
  localparam logic [2:0] TFC_LIMIT    = 3'd3;
  localparam logic [2:0] TFC_MODE     = 3'd4;

  typedef struct packed {
    logic [TRACE_PC_WIDTH-1:0]           pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
  } trace_entry_t;

endpackage

// File: rtl/trace_skid_buffer.sv
// Two-entry FIFO with registered head toward a valid/ready sink.
// A push while full is accepted only when the head pops in the same cycle.
module trace_skid_buffer
  import continuous_monitoring_system_pkg::*;
#(
  parameter type entry_t = trace_entry_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  logic   in_valid,
  input  entry_t in_data,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_data,
  output logic   full
);

  logic [1:0] count;
  entry_t     slot0;
  entry_t     slot1;
  logic       push;
  logic       pop;

  assign full      = (count == 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = slot0;
  assign pop       = out_valid && out_ready;
  assign push      = in_valid && (!full || out_ready);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the new entry lands behind whatever remains
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/trace_filter_ctrl.sv
// Run controller for trace_filter: arms a capture window, gates pc_valid into the
// filter and buffers kept instructions toward the trace sink.
module trace_filter_ctrl
  import continuous_monitoring_system_pkg::*;
#(
  parameter int unsigned PC_WIDTH      = 64,
  parameter int unsigned COUNTER_WIDTH = 32,
  parameter int unsigned INSTR_WIDTH   = RISC_V_INSTRUCTION_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_wr_en,
  input  logic [2:0]               cfg_addr,
  input  logic [63:0]              cfg_wdata,
  input  logic [PC_WIDTH-1:0]      pc,
  input  logic                     pc_valid,
  input  logic [INSTR_WIDTH-1:0]   instr,
  output logic                     filt_pc_valid,
  output logic [4:0]               filt_mode,
  input  logic                     filt_drop_instr,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [PC_WIDTH-1:0]      trace_pc,
  output logic [INSTR_WIDTH-1:0]   trace_instr,
  output logic [1:0]               state,
  output logic [COUNTER_WIDTH-1:0] kept_count,
  output logic [COUNTER_WIDTH-1:0] overflow_count,
  output logic                     done_pulse
);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  trace_ctrl_state_t        state_q;
  logic [PC_WIDTH-1:0]      start_pc;
  logic [PC_WIDTH-1:0]      end_pc;
  logic [COUNTER_WIDTH-1:0] limit;
  logic [4:0]               mode;

  logic   ctrl_wr, abort, arm, trigger, active, push_ok, buf_full;
  logic   accepted, overflowed, end_hit, limit_hit, finish, flush;
  entry_t push_data, head;

  assign ctrl_wr = cfg_wr_en && (cfg_addr == TFC_CTRL);
  assign abort   = ctrl_wr && cfg_wdata[1];
  assign arm     = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1];
  assign trigger = (state_q == TFC_ARMED) && pc_valid && (pc == start_pc);
  assign active  = (state_q == TFC_RUNNING) || trigger;

  assign filt_pc_valid = pc_valid && active;
  assign push_ok       = filt_pc_valid && !filt_drop_instr && !abort;
  // a full buffer still takes the push when its head leaves in the same cycle
  assign accepted      = push_ok && (!buf_full || trace_ready);
  assign overflowed    = push_ok && buf_full && !trace_ready;
  assign end_hit       = filt_pc_valid && (pc == end_pc);
  assign limit_hit     = accepted && (limit != '0) && (kept_count + CNT_ONE == limit);
  assign finish        = end_hit || limit_hit;
  assign flush         = abort || (arm && state_q == TFC_IDLE);

  assign push_data.pc    = pc;
  assign push_data.instr = instr;

  trace_skid_buffer #(
    .entry_t (entry_t)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (accepted),
    .in_data   (push_data),
    .out_valid (trace_valid),
    .out_ready (trace_ready),
    .out_data  (head),
    .full      (buf_full)
  );

  assign trace_pc    = head.pc;
  assign trace_instr = head.instr;
  assign state       = state_q;
  assign filt_mode   = mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= TFC_IDLE;
      start_pc       <= '0;
      end_pc         <= '0;
      limit          <= '0;
      mode           <= '0;
      kept_count     <= '0;
      overflow_count <= '0;
      done_pulse     <= 1'b0;
    end else begin
      done_pulse <= 1'b0;
      if (accepted)
        kept_count <= kept_count + CNT_ONE;
      else if (overflowed && overflow_count != '1)
        overflow_count <= overflow_count + CNT_ONE;

      if (abort) begin
        state_q <= TFC_IDLE;
      end else begin
        unique case (state_q)
          TFC_IDLE: begin
            if (arm) begin
              state_q        <= TFC_ARMED;
              kept_count     <= '0;
              overflow_count <= '0;
            end
            if (cfg_wr_en) begin
              unique case (cfg_addr)
                TFC_START_PC: start_pc <= cfg_wdata[PC_WIDTH-1:0];
                TFC_END_PC:   end_pc   <= cfg_wdata[PC_WIDTH-1:0];
                TFC_LIMIT:    limit    <= cfg_wdata[COUNTER_WIDTH-1:0];
                TFC_MODE:     mode     <= cfg_wdata[4:0];
                default: ;
              endcase
            end
          end
          TFC_ARMED: begin
            if (trigger) begin
              state_q    <= finish ? TFC_DONE : TFC_RUNNING;
              done_pulse <= finish;
            end
          end
          TFC_RUNNING: begin
            if (finish) begin
              state_q    <= TFC_DONE;
              done_pulse <= 1'b1;
            end
          end
          TFC_DONE: begin
            if (arm) state_q <= TFC_IDLE;
          end
          default: state_q <= TFC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trace_filter_ctrl.sv
// Self-checking bench for trace_filter_ctrl: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_trace_filter_ctrl;
  import continuous_monitoring_system_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [63:0] cfg_wdata = '0;
  logic [63:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        filt_pc_valid;
  logic [4:0]  filt_mode;
  logic        filt_drop_instr = 1'b0;
  logic        trace_valid;
  logic        trace_ready = 1'b0;
  logic [63:0] trace_pc;
  logic [31:0] trace_instr;
  logic [1:0]  state;
  logic [31:0] kept_count;
  logic [31:0] overflow_count;
  logic        done_pulse;

  trace_filter_ctrl #(
    .PC_WIDTH      (64),
    .COUNTER_WIDTH (32),
    .INSTR_WIDTH   (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_addr        (cfg_addr),
    .cfg_wdata       (cfg_wdata),
    .pc              (pc),
    .pc_valid        (pc_valid),
    .instr           (instr),
    .filt_pc_valid   (filt_pc_valid),
    .filt_mode       (filt_mode),
    .filt_drop_instr (filt_drop_instr),
    .trace_valid     (trace_valid),
    .trace_ready     (trace_ready),
    .trace_pc        (trace_pc),
    .trace_instr     (trace_instr),
    .state           (state),
    .kept_count      (kept_count),
    .overflow_count  (overflow_count),
    .done_pulse      (done_pulse)
  );

  always #5 clk = ~clk;

  localparam int S_IDLE = 0, S_ARMED = 1, S_RUNNING = 2, S_DONE = 3;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } ent_t;

  int checks = 0;
  int failures = 0;

  ent_t        m_q[$];
  int          m_state = S_IDLE;
  logic [63:0] m_start = '0, m_end = '0;
  logic [31:0] m_limit = '0, m_kept = '0, m_ovf = '0;
  logic [4:0]  m_mode = '0;
  bit          m_done = 1'b0;
  logic [63:0] seen[$];

  // Advance the reference model on the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit wr, abort, arm, trig, act, keep, endh, limh, acc;
    int old;
    ent_t e;
    if (trace_valid && trace_ready) seen.push_back(trace_pc);
    if (rst) begin
      m_state = S_IDLE; m_start = '0; m_end = '0; m_limit = '0; m_mode = '0;
      m_kept = '0; m_ovf = '0; m_done = 1'b0; m_q.delete();
    end else begin
      wr    = cfg_wr_en && cfg_addr == 3'd0;
      abort = wr && cfg_wdata[1];
      arm   = wr && cfg_wdata[0] && !abort;
      trig  = (m_state == S_ARMED) && pc_valid && pc == m_start;
      act   = pc_valid && (m_state == S_RUNNING || trig);
      keep  = act && !filt_drop_instr && !abort;
      endh  = act && pc == m_end;
      if (m_q.size() > 0 && trace_ready) void'(m_q.pop_front());
      acc = 1'b0;
      if (keep) begin
        if (m_q.size() < 2) begin
          e.pc = pc; e.instr = instr;
          m_q.push_back(e);
          m_kept = m_kept + 1;
          acc = 1'b1;
        end else if (m_ovf != 32'hFFFF_FFFF) begin
          m_ovf = m_ovf + 1;
        end
      end
      limh = acc && m_limit != 0 && m_kept == m_limit;
      old = m_state;
      if (abort) begin
        m_state = S_IDLE;
        m_q.delete();
      end else begin
        case (m_state)
          S_IDLE: begin
            if (arm) begin
              m_state = S_ARMED; m_kept = '0; m_ovf = '0; m_q.delete();
            end
            if (cfg_wr_en) begin
              case (cfg_addr)
                3'd1: m_start = cfg_wdata;
                3'd2: m_end   = cfg_wdata;
                3'd3: m_limit = cfg_wdata[31:0];
                3'd4: m_mode  = cfg_wdata[4:0];
                default: ;
              endcase
            end
          end
          S_ARMED:   if (trig) m_state = (endh || limh) ? S_DONE : S_RUNNING;
          S_RUNNING: if (endh || limh) m_state = S_DONE;
          default:   if (arm) m_state = S_IDLE;
        endcase
      end
      m_done = (m_state == S_DONE) && (old != S_DONE);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cfg_wr_en = 1'b0; pc_valid = 1'b0; filt_drop_instr = 1'b0; trace_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [63:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic drive_instr(input logic [63:0] p, input logic drop);
    pc = p; pc_valid = 1'b1; instr = $urandom; filt_drop_instr = drop;
    tick();
    pc_valid = 1'b0; filt_drop_instr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    pc_valid = 1'b1; pc = '0;
    #1;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (kept_count !== 32'd0) begin failures++; $display("FAIL reset_kept got=%0d exp=0", kept_count); end
    checks++; if (overflow_count !== 32'd0) begin failures++; $display("FAIL reset_ovf got=%0d exp=0", overflow_count); end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL reset_tvalid got=%b exp=0", trace_valid); end
    checks++; if (done_pulse !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done_pulse); end
    checks++; if (filt_mode !== 5'd0) begin failures++; $display("FAIL reset_mode got=%0h exp=0", filt_mode); end
    checks++; if (filt_pc_valid !== 1'b0) begin failures++; $display("FAIL reset_fpv got=%b exp=0", filt_pc_valid); end
    pc_valid = 1'b0;
  endtask

  task automatic test_window();
    int pulses = 0;
    logic [63:0] p;
    logic exp_fpv;
    cfg_write(3'd1, 64'h100);
    cfg_write(3'd2, 64'h10C);
    cfg_write(3'd4, 64'b00011);
    trace_ready = 1'b1;
    cfg_write(3'd0, 64'd1);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL window_armed got=%0d exp=1", state); end
    checks++; if (filt_mode !== 5'b00011) begin failures++; $display("FAIL window_mode got=%0h exp=3", filt_mode); end
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      p = 64'hFC + 64'(4 * i);
      pc = p; pc_valid = 1'b1; instr = $urandom; filt_drop_instr = 1'b0;
      #1;
      exp_fpv = (p >= 64'h100) && (p <= 64'h10C);
      checks++; if (filt_pc_valid !== exp_fpv) begin failures++; $display("FAIL window_fpv pc=%0h got=%b exp=%b", p, filt_pc_valid, exp_fpv); end
      tick();
      pc_valid = 1'b0;
      if (done_pulse) pulses++;
    end
    repeat (3) begin tick(); if (done_pulse) pulses++; end
    checks++; if (seen.size() != 4) begin failures++; $display("FAIL window_count got=%0d exp=4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 64'h100 + 64'(4 * k)) begin failures++; $display("FAIL window_pc[%0d] got=%0h exp=%0h", k, seen[k], 64'h100 + 64'(4 * k)); end
    end
    checks++; if (kept_count !== 32'd4) begin failures++; $display("FAIL window_kept got=%0d exp=4", kept_count); end
    checks++; if (pulses != 1) begin failures++; $display("FAIL window_pulses got=%0d exp=1", pulses); end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL window_done got=%0d exp=3", state); end
  endtask

  task automatic test_limit();
    logic [1:0] exp_st;
    cfg_write(3'd0, 64'd1);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL limit_arm_in_done got=%0d exp=0", state); end
    cfg_write(3'd3, 64'd3);
    cfg_write(3'd1, 64'h1000);
    cfg_write(3'd2, 64'hDEAD_0000);
    trace_ready = 1'b1;
    cfg_write(3'd0, 64'd1);
    seen.delete();
    for (int i = 0; i < 10; i++) begin
      drive_instr(64'h1000 + 64'(4 * i), 1'b0);
      exp_st = (i >= 2) ? 2'd3 : 2'd2;
      checks++; if (state !== exp_st) begin failures++; $display("FAIL limit_state[%0d] got=%0d exp=%0d", i, state, exp_st); end
    end
    repeat (3) tick();
    checks++; if (kept_count !== 32'd3) begin failures++; $display("FAIL limit_kept got=%0d exp=3", kept_count); end
    checks++; if (seen.size() != 3) begin failures++; $display("FAIL limit_count got=%0d exp=3", seen.size()); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 64'h1000 + 64'(4 * k)) begin failures++; $display("FAIL limit_pc[%0d] got=%0h exp=%0h", k, seen[k], 64'h1000 + 64'(4 * k)); end
    end
  endtask

  task automatic test_overflow();
    cfg_write(3'd0, 64'd2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL ovf_abort_idle got=%0d exp=0", state); end
    checks++; if (kept_count !== 32'd3) begin failures++; $display("FAIL ovf_abort_hold got=%0d exp=3", kept_count); end
    cfg_write(3'd3, 64'd0);
    cfg_write(3'd1, 64'h2000);
    trace_ready = 1'b0;
    cfg_write(3'd0, 64'd1);
    for (int i = 0; i < 5; i++) drive_instr(64'h2000 + 64'(4 * i), 1'b0);
    checks++; if (kept_count !== 32'd2) begin failures++; $display("FAIL ovf_kept got=%0d exp=2", kept_count); end
    checks++; if (overflow_count !== 32'd3) begin failures++; $display("FAIL ovf_count got=%0d exp=3", overflow_count); end
    checks++; if (trace_valid !== 1'b1 || trace_pc !== 64'h2000) begin failures++; $display("FAIL ovf_head got=%b/%0h exp=1/2000", trace_valid, trace_pc); end
    seen.delete();
    trace_ready = 1'b1;
    repeat (3) tick();
    checks++; if (seen.size() != 2) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=2", seen.size()); end
    for (int k = 0; k < 2 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 64'h2000 + 64'(4 * k)) begin failures++; $display("FAIL ovf_drain_pc[%0d] got=%0h exp=%0h", k, seen[k], 64'h2000 + 64'(4 * k)); end
    end
    checks++; if (trace_valid !== 1'b0 || state !== 2'd2) begin failures++; $display("FAIL ovf_after got=%b/%0d exp=0/2", trace_valid, state); end
  endtask

  task automatic test_abort();
    trace_ready = 1'b0;
    drive_instr(64'h3000, 1'b0);
    drive_instr(64'h3004, 1'b0);
    checks++; if (trace_valid !== 1'b1 || kept_count !== 32'd4) begin failures++; $display("FAIL abort_pre got=%b/%0d exp=1/4", trace_valid, kept_count); end
    cfg_write(3'd0, 64'd2);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL abort_state got=%0d exp=0", state); end
    checks++; if (trace_valid !== 1'b0) begin failures++; $display("FAIL abort_flush got=%b exp=0", trace_valid); end
    checks++; if (kept_count !== 32'd4 || overflow_count !== 32'd3) begin failures++; $display("FAIL abort_counters got=%0d/%0d exp=4/3", kept_count, overflow_count); end
  endtask

  task automatic test_drop();
    cfg_write(3'd1, 64'h3000);
    cfg_write(3'd2, 64'h3014);
    trace_ready = 1'b1;
    cfg_write(3'd0, 64'd1);
    seen.delete();
    for (int i = 0; i < 6; i++) begin
      pc = 64'h3000 + 64'(4 * i); pc_valid = 1'b1; instr = $urandom; filt_drop_instr = (i % 2 == 1);
      #1;
      checks++; if (filt_pc_valid !== 1'b1) begin failures++; $display("FAIL drop_fpv[%0d] got=%b exp=1", i, filt_pc_valid); end
      tick();
      pc_valid = 1'b0; filt_drop_instr = 1'b0;
    end
    repeat (3) tick();
    checks++; if (kept_count !== 32'd3) begin failures++; $display("FAIL drop_kept got=%0d exp=3", kept_count); end
    checks++; if (state !== 2'd3) begin failures++; $display("FAIL drop_end_done got=%0d exp=3", state); end
    for (int k = 0; k < 3 && k < seen.size(); k++) begin
      checks++; if (seen[k] !== 64'h3000 + 64'(8 * k)) begin failures++; $display("FAIL drop_pc[%0d] got=%0h exp=%0h", k, seen[k], 64'h3000 + 64'(8 * k)); end
    end
  endtask

  task automatic test_arm_abort_and_start_eq_end();
    cfg_write(3'd0, 64'd2);
    cfg_write(3'd0, 64'd3);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL arm_abort_idle got=%0d exp=0", state); end
    cfg_write(3'd1, 64'h200);
    cfg_write(3'd2, 64'h200);
    trace_ready = 1'b1;
    cfg_write(3'd0, 64'd1);
    seen.delete();
    drive_instr(64'h1FC, 1'b0);
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL seq_still_armed got=%0d exp=1", state); end
    drive_instr(64'h200, 1'b0);
    checks++; if (state !== 2'd3 || done_pulse !== 1'b1) begin failures++; $display("FAIL seq_done got=%0d/%b exp=3/1", state, done_pulse); end
    checks++; if (kept_count !== 32'd1) begin failures++; $display("FAIL seq_kept got=%0d exp=1", kept_count); end
    drive_instr(64'h200, 1'b0);
    checks++; if (done_pulse !== 1'b0 || kept_count !== 32'd1) begin failures++; $display("FAIL seq_after got=%b/%0d exp=0/1", done_pulse, kept_count); end
    repeat (2) tick();
    checks++; if (seen.size() != 1 || seen[0] !== 64'h200) begin failures++; $display("FAIL seq_trace got=%0d entries exp=1 at 200", seen.size()); end
  endtask

  task automatic test_random();
    logic exp_fpv;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom % 500 == 0);
      pc_valid = ($urandom % 4 != 0);
      pc = 64'h40 + 64'(4 * ($urandom % 8));
      instr = $urandom;
      filt_drop_instr = ($urandom % 3 == 0);
      trace_ready = ($urandom % 3 != 0);
      cfg_wr_en = 1'b0;
      if (m_state == S_IDLE && $urandom % 3 == 0) begin
        cfg_wr_en = 1'b1;
        cfg_addr = 3'($urandom % 5);
        case (cfg_addr)
          3'd0:    cfg_wdata = 64'd1;
          3'd1,
          3'd2:    cfg_wdata = 64'h40 + 64'(4 * ($urandom % 8));
          3'd3:    cfg_wdata = 64'($urandom % 5);
          default: cfg_wdata = {$urandom, $urandom};
        endcase
      end else if ($urandom % 40 == 0) begin
        cfg_wr_en = 1'b1;
        cfg_addr = 3'($urandom);
        cfg_wdata = {$urandom, $urandom};
        if (cfg_addr == 3'd0 && $urandom % 3 != 0) cfg_wdata[1] = 1'b0;
      end
      #1;
      exp_fpv = !rst && pc_valid && (m_state == S_RUNNING || (m_state == S_ARMED && pc == m_start));
      if (!rst) begin
        checks++; if (filt_pc_valid !== exp_fpv) begin failures++; $display("FAIL rnd_fpv c=%0d got=%b exp=%b", c, filt_pc_valid, exp_fpv); end
      end
      tick();
      checks++; if (state !== 2'(m_state)) begin failures++; $display("FAIL rnd_state c=%0d got=%0d exp=%0d", c, state, m_state); end
      checks++; if (kept_count !== m_kept || overflow_count !== m_ovf) begin failures++; $display("FAIL rnd_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, kept_count, overflow_count, m_kept, m_ovf); end
      checks++; if (done_pulse !== m_done) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, done_pulse, m_done); end
      checks++; if (filt_mode !== m_mode) begin failures++; $display("FAIL rnd_mode c=%0d got=%0h exp=%0h", c, filt_mode, m_mode); end
      checks++; if (trace_valid !== (m_q.size() > 0)) begin failures++; $display("FAIL rnd_tvalid c=%0d got=%b exp=%0d", c, trace_valid, m_q.size()); end
      if (m_q.size() > 0) begin
        checks++; if (trace_pc !== m_q[0].pc || trace_instr !== m_q[0].instr) begin failures++; $display("FAIL rnd_head c=%0d got=%0h/%0h exp=%0h/%0h", c, trace_pc, trace_instr, m_q[0].pc, m_q[0].instr); end
      end
    end
    rst = 1'b0; cfg_wr_en = 1'b0; pc_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_window();
    test_limit();
    test_overflow();
    test_abort();
    test_drop();
    test_arm_abort_and_start_eq_end();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trace_filter_ctrl.md
# trace_filter_ctrl

Run controller for `trace_filter` in the continuous monitoring system. It arms a trace capture window bounded by start/end PCs or a kept-instruction limit, and gates `pc_valid` into the filter. It pushes instructions the filter keeps into a 2-entry output buffer with a valid/ready handshake toward the trace sink. It exposes run state, counters and a completion pulse to software.

## Interface

Parameters:
- `PC_WIDTH`, 64, program counter width.
- `COUNTER_WIDTH`, 32, width of the kept, overflow and limit counters.
- `INSTR_WIDTH`, `RISC_V_INSTRUCTION_WIDTH`, instruction word width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_wr_en`  in  1  config write strobe.
- `cfg_addr`  in  3  register select (see Operation).
- `cfg_wdata`  in  64  write data.
- `pc`  in  PC_WIDTH  PC of the retiring instruction.
- `pc_valid`  in  1  `pc` and `instr` are valid this cycle.
- `instr`  in  INSTR_WIDTH  retiring instruction.
- `filt_pc_valid`  out  1  gated `pc_valid` driven to `trace_filter`.
- `filt_mode`  out  5  runtime send-after enables, in order {interrupt, trap, wfi, jump, branch}.
- `filt_drop_instr`  in  1  filter verdict for the instruction presented in the same cycle.
- `trace_valid`  out  1  output buffer head is valid.
- `trace_ready`  in  1  sink accepts the head.
- `trace_pc`  out  PC_WIDTH  head PC.
- `trace_instr`  out  INSTR_WIDTH  head instruction.
- `state`  out  2  current run state.
- `kept_count`  out  COUNTER_WIDTH  instructions pushed into the buffer this run.
- `overflow_count`  out  COUNTER_WIDTH  kept instructions lost because the buffer was full; saturating.
- `done_pulse`  out  1  one-cycle pulse on entering DONE.

## Operation

- Register map (writes only):
  - 0 CTRL: bit0 arm, bit1 abort.
  - 1 START_PC.
  - 2 END_PC.
  - 3 LIMIT (low COUNTER_WIDTH bits; 0 means unlimited).
  - 4 MODE (low 5 bits).
- Writes to addresses 1–4 take effect only in IDLE and are ignored otherwise.
- Writes to addresses 5–7 are ignored.
- States (`trace_ctrl_state_t`): IDLE=0, ARMED=1, RUNNING=2, DONE=3.
- IDLE → ARMED on an arm write. The arm write clears `kept_count`, `overflow_count` and the buffer.
- ARMED → RUNNING when `pc_valid && pc==START_PC`. The trigger instruction is itself processed as RUNNING in that cycle.
- `filt_pc_valid = pc_valid && (state==RUNNING || ARMED trigger match)`.
- keep = `filt_pc_valid && !filt_drop_instr`.
- On keep:
  - Buffer not full → push {pc, instr} and increment `kept_count`.
  - Buffer full → increment `overflow_count` (saturating at all-ones). The CPU is never stalled.
- RUNNING → DONE after the cycle in which either:
  - a `filt_pc_valid` instruction has `pc==END_PC` (whether kept or dropped), or
  - `kept_count` reaches a nonzero LIMIT.
- In DONE the buffer keeps draining; no new pushes occur.
- DONE → IDLE on an arm or abort write. Arm in DONE goes to IDLE, not ARMED; software re-arms.
- Abort in any state → IDLE on the next edge and flushes the buffer. Counters hold their values.
- Arm and abort both set: abort wins.
- Start and end conditions in the same cycle (START_PC==END_PC): ARMED → DONE directly. The trigger instruction is still kept if the filter allows it.
- Buffer push and pop in the same cycle with the buffer full: the push is accepted and occupancy stays 2. Buffer order is FIFO.
- `kept_count` does not wrap: LIMIT ≤ all-ones, and counting stops on DONE.

## Timing

- Reset values: `state`=IDLE, all counters 0, buffer empty, `trace_valid`=0, `done_pulse`=0, `filt_mode`=0, START/END/LIMIT=0.
- `filt_pc_valid` is combinational from `pc_valid` and state, with zero latency.
- `filt_drop_instr` must settle in the same cycle.
- Kept instruction to `trace_valid`: 1 cycle when the buffer is empty (registered).
- `trace_pc`/`trace_instr` stay stable while `trace_valid && !trace_ready`.
- A pop occurs on `trace_valid && trace_ready`.
- Config write to effect: next edge.
- `done_pulse` is high in the first cycle that `state==DONE`.
- `rst` mid-run overrides everything on the next edge.

## Structure

- Add to `continuous_monitoring_system_pkg`: `trace_ctrl_state_t` enum, CFG address constants (`TFC_CTRL`, `TFC_START_PC`, `TFC_END_PC`, `TFC_LIMIT`, `TFC_MODE`), and a `trace_entry_t` struct {pc, instr}.
- One sub-module: `trace_skid_buffer`, a 2-entry valid/ready FIFO of `trace_entry_t` with a full flag.
- `trace_filter` is instantiated by the parent alongside this block, not inside it.

## Test plan

- Reset, write START=0x100, END=0x10C, MODE=0b00011, arm. Drive PCs 0xFC..0x110 all kept with `trace_ready`=1 → trace out 0x100,0x104,0x108,0x10C; `kept_count`=4; `done_pulse` once; state DONE.
- LIMIT=3, END unreachable, 10 kept instructions → exactly 3 pushed; DONE after the 3rd.
- `trace_ready`=0, 5 kept instructions → 2 buffered, `overflow_count`=3. Then ready=1 → first two entries emerge in order.
- `filt_drop_instr` alternating 1/0 over 6 instructions → `kept_count`=3. END_PC on a dropped instruction still reaches DONE.
- Abort written while RUNNING with 2 buffered entries → IDLE next cycle, `trace_valid`=0, counters unchanged.
- Arm and abort written together in IDLE → stays IDLE. START==END=0x200 → ARMED goes straight to DONE with `kept_count`=1.
